// File: rtl/disp_sched_pkg.sv
// Shared types and helpers for the display source scheduler.
// State encoding, source count, data width, one-hot and round-robin search.
package disp_sched_pkg;

    localparam int N_SRC = 4;
    localparam int DW    = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DWELL,
        S_HOLD,
        S_MANUAL
    } state_t;

    function automatic logic [N_SRC-1:0] onehot(input logic [1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Returns {found, index}. Searches from+1, from+2, ... wrapping, with
    // 'from' itself tried last. Passing from=3 yields the lowest set bit.
    function automatic logic [2:0] next_req(input logic [N_SRC-1:0] v,
                                            input logic [1:0]       from);
        logic [1:0] k;
        next_req = 3'b000;
        for (int i = N_SRC; i >= 1; i--) begin
            k = from + 2'(i);
            if (v[k]) begin
                next_req = {1'b1, k};
            end
        end
    endfunction

endpackage

// File: rtl/sched_timer.sv
// Loadable down-counter shared by the dwell and hold phases.
// Ports: clk, rst_n (sync, active-low), load, value (load value), expire.
module sched_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] value,
    output logic          expire
);

    logic [TW-1:0] cnt;

    // Saturates at zero, so it never wraps past the load value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - TW'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/disp_sched.sv
// Display source scheduler: manual select, timed round-robin, event hold.
// Ports: clk, rst_n, mode, man_sel, req, evt, src_data -> grant, sel, disp_num, hold_active.
module disp_sched
    import disp_sched_pkg::*;
#(
    parameter int N_SRC     = disp_sched_pkg::N_SRC,
    parameter int DWELL_CYC = 50_000_000,
    parameter int HOLD_CYC  = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [1:0]            man_sel,
    input  logic [N_SRC-1:0]      req,
    input  logic [N_SRC-1:0]      evt,
    input  logic [N_SRC*DW-1:0]   src_data,
    output logic [N_SRC-1:0]      grant,
    output logic [1:0]            sel,
    output logic [DW-1:0]         disp_num,
    output logic                  hold_active
);

    localparam int DWELL_W = $clog2(DWELL_CYC);
    localparam int HOLD_W  = $clog2(HOLD_CYC);
    localparam int TW_RAW  = (DWELL_W > HOLD_W) ? DWELL_W : HOLD_W;
    localparam int TW      = (TW_RAW < 1) ? 1 : TW_RAW;

    // Timer runs load..0 inclusive, giving exactly *_CYC cycles per phase.
    localparam logic [TW-1:0] DWELL_LD = TW'(DWELL_CYC - 1);
    localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYC - 1);

    state_t        state;
    state_t        state_n;
    logic [1:0]    sel_n;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_exp;
    logic [2:0]    evt_lo;
    logic [2:0]    req_lo;
    logic [2:0]    req_nx;

    assign evt_lo = next_req(evt, 2'd3);
    assign req_lo = next_req(req, 2'd3);
    assign req_nx = next_req(req, sel);

    sched_timer #(
        .TW (TW)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .value  (tmr_val),
        .expire (tmr_exp)
    );

    always_comb begin
        state_n  = state;
        sel_n    = sel;
        tmr_load = 1'b0;
        tmr_val  = DWELL_LD;
        if (!mode) begin
            state_n = S_MANUAL;
            sel_n   = man_sel;
        end else begin
            unique case (state)
                S_MANUAL: begin
                    if (req_lo[2]) begin
                        state_n  = S_DWELL;
                        sel_n    = req_lo[1:0];
                        tmr_load = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                        sel_n   = 2'd0;
                    end
                end
                S_IDLE: begin
                    if (evt_lo[2]) begin
                        state_n  = S_HOLD;
                        sel_n    = evt_lo[1:0];
                        tmr_load = 1'b1;
                        tmr_val  = HOLD_LD;
                    end else if (req_lo[2]) begin
                        state_n  = S_DWELL;
                        sel_n    = req_lo[1:0];
                        tmr_load = 1'b1;
                    end else begin
                        sel_n = 2'd0;
                    end
                end
                S_DWELL: begin
                    if (evt_lo[2]) begin
                        state_n  = S_HOLD;
                        sel_n    = evt_lo[1:0];
                        tmr_load = 1'b1;
                        tmr_val  = HOLD_LD;
                    end else if (!req[sel] || tmr_exp) begin
                        // Sole requester at expiry reselects itself: reload only.
                        if (req_nx[2]) begin
                            sel_n    = req_nx[1:0];
                            tmr_load = 1'b1;
                        end else begin
                            state_n = S_IDLE;
                            sel_n   = 2'd0;
                        end
                    end
                end
                S_HOLD: begin
                    if (evt_lo[2]) begin
                        sel_n    = evt_lo[1:0];
                        tmr_load = 1'b1;
                        tmr_val  = HOLD_LD;
                    end else if (tmr_exp) begin
                        if (req_nx[2]) begin
                            state_n  = S_DWELL;
                            sel_n    = req_nx[1:0];
                            tmr_load = 1'b1;
                        end else begin
                            state_n = S_IDLE;
                            sel_n   = 2'd0;
                        end
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    sel_n   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            sel      <= 2'd0;
            disp_num <= '0;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            if (state_n == S_IDLE) begin
                disp_num <= '0;
            end else begin
                disp_num <= src_data[int'(sel_n) * DW +: DW];
            end
        end
    end

    assign grant       = (state == S_IDLE) ? '0 : onehot(sel);
    assign hold_active = (state == S_HOLD);

endmodule

// File: tb/tb_disp_sched.sv
// Scoreboard bench for disp_sched with short dwell/hold timers.
// Expected owner per cycle is queued at drive time and checked after the edge.
module tb_disp_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b1;
    logic [1:0]  man_sel = 2'd0;
    logic [3:0]  req = 4'd0;
    logic [3:0]  evt = 4'd0;
    logic [63:0] src_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    logic [3:0]  grant;
    logic [1:0]  sel;
    logic [15:0] disp_num;
    logic        hold_active;

    typedef struct {
        logic [3:0]  g;
        logic [1:0]  s;
        logic [15:0] d;
        logic        h;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    disp_sched #(
        .N_SRC     (4),
        .DWELL_CYC (4),
        .HOLD_CYC  (6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .man_sel     (man_sel),
        .req         (req),
        .evt         (evt),
        .src_data    (src_data),
        .grant       (grant),
        .sel         (sel),
        .disp_num    (disp_num),
        .hold_active (hold_active)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // own < 0 means idle/reset: all outputs zero.
    task automatic step(input string tag, input logic m,
                        input logic [1:0] ms, input logic [3:0] r,
                        input logic [3:0] e, input logic rn,
                        input int own, input logic h);
        exp_t x;
        exp_t y;
        mode    = m;
        man_sel = ms;
        req     = r;
        evt     = e;
        rst_n   = rn;
        x.g = (own < 0) ? 4'b0000 : 4'(1 << own);
        x.s = (own < 0) ? 2'd0 : 2'(own);
        x.d = (own < 0) ? 16'h0000 : 16'(16'h1111 * (own + 1));
        x.h = h;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, " sb_empty"}, 32'd0, 32'd1);
        end else begin
            y = sb.pop_front();
            chk({tag, " grant"}, 32'(grant), 32'(y.g));
            chk({tag, " sel"}, 32'(sel), 32'(y.s));
            chk({tag, " disp"}, 32'(disp_num), 32'(y.d));
            chk({tag, " hold"}, 32'(hold_active), 32'(y.h));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step("rst", 1, 0, 4'b0000, 4'b0000, 0, -1, 0);
        step("rst", 1, 0, 4'b0101, 4'b0000, 0, -1, 0);

        for (int i = 0; i < 4; i++) step("rr0", 1, 0, 4'b0101, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step("rr2", 1, 0, 4'b0101, 0, 1, 2, 0);
        for (int i = 0; i < 2; i++) step("rr0b", 1, 0, 4'b0101, 0, 1, 0, 0);
        step("rst_dwell", 1, 0, 4'b0101, 0, 0, -1, 0);

        for (int i = 0; i < 12; i++) step("single", 1, 0, 4'b1000, 0, 1, 3, 0);

        step("drop_rot", 1, 0, 4'b0011, 4'b0000, 1, 0, 0);
        step("hold_in", 1, 0, 4'b0011, 4'b0110, 1, 1, 1);
        for (int i = 0; i < 5; i++) step("hold", 1, 0, 4'b0011, 0, 1, 1, 1);
        step("resume", 1, 0, 4'b0011, 4'b0000, 1, 0, 0);

        step("dwell2", 1, 0, 4'b0001, 4'b0000, 1, 0, 0);
        step("drop_idle", 1, 0, 4'b0000, 4'b0000, 1, -1, 0);

        step("evt_idle", 1, 0, 4'b0000, 4'b1000, 1, 3, 1);
        for (int i = 0; i < 2; i++) step("hold3", 1, 0, 4'b0000, 0, 1, 3, 1);
        step("rearm", 1, 0, 4'b0000, 4'b0010, 1, 1, 1);
        for (int i = 0; i < 5; i++) step("hold1", 1, 0, 4'b0000, 0, 1, 1, 1);
        step("hold_exp", 1, 0, 4'b0000, 4'b0000, 1, -1, 0);

        step("man", 0, 2, 4'b0000, 4'b0001, 1, 2, 0);
        step("man2", 0, 2, 4'b1111, 4'b1000, 1, 2, 0);
        step("auto", 1, 2, 4'b0010, 4'b0000, 1, 1, 0);

        step("evt_dw", 1, 0, 4'b0010, 4'b0100, 1, 2, 1);
        step("rst_hold", 1, 0, 4'b0010, 4'b0000, 0, -1, 0);
        step("post_rst", 1, 0, 4'b0000, 4'b0000, 1, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
